// File: rtl/islem_denetleyici_if.sv
// Port bundle between the sequencer (initiator) and the floating-point islem unit (target).
interface islem_denetleyici_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic              alu_enable;
  logic [DATA_W-1:0] alu_sayi1;
  logic [DATA_W-1:0] alu_sayi2;
  logic [1:0]        alu_islem_turu;
  logic [ADDR_W-1:0] alu_adres;
  logic [DATA_W-1:0] alu_sonuc;
  logic              alu_bitti;

  modport master (
    output alu_enable, alu_sayi1, alu_sayi2, alu_islem_turu, alu_adres,
    input  alu_sonuc, alu_bitti
  );

  modport slave (
    input  alu_enable, alu_sayi1, alu_sayi2, alu_islem_turu, alu_adres,
    output alu_sonuc, alu_bitti
  );
endinterface

// File: rtl/islem_denetleyici.sv
// Sequencer: fetches operand records from the operand RAM, runs each through the islem unit
// and writes results to the result RAM, for a programmed number of operations.
module islem_denetleyici #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 basla,
  input  logic [ADDR_W-1:0]    islem_sayisi,
  output logic [ADDR_W-1:0]    mem_adres,
  input  logic [DATA_W-1:0]    mem_veri,
  islem_denetleyici_if.master  alu,
  output logic                 yaz_en,
  output logic [ADDR_W-1:0]    yaz_adres,
  output logic [DATA_W-1:0]    yaz_veri,
  output logic                 mesgul,
  output logic                 bitti,
  output logic                 hata
);
  localparam int unsigned SAYAC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {BOSTA, OKU0, OKU1, OKU2, OKU3, BEKLE, YAZ, BITIR} durum_t;

  durum_t              state_q, state_d;
  logic [ADDR_W-1:0]   n_q, n_d, i_q, i_d, taban_q, taban_d;
  logic [SAYAC_W-1:0]  sayac_q, sayac_d;
  logic [ADDR_W-1:0]   mem_adres_q, mem_adres_d, alu_adres_q, alu_adres_d;
  logic [ADDR_W-1:0]   yaz_adres_q, yaz_adres_d;
  logic [DATA_W-1:0]   sayi1_q, sayi1_d, sayi2_q, sayi2_d, yaz_veri_q, yaz_veri_d;
  logic [1:0]          tur_q, tur_d;
  logic                alu_enable_q, alu_enable_d, yaz_en_q, yaz_en_d;
  logic                mesgul_q, mesgul_d, bitti_q, bitti_d, hata_q, hata_d;
  logic                zaman_asimi_c, son_islem_c, kabul_c;

  assign kabul_c       = (state_q == BOSTA) && basla;
  assign zaman_asimi_c = (sayac_q == SAYAC_W'(TIMEOUT - 1));
  assign son_islem_c   = ((i_q + ADDR_W'(1)) == n_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOSTA;
    else     state_q <= state_d;
  end

  // Next-state logic; alu_bitti takes priority over a coinciding timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOSTA:   if (basla) state_d = (islem_sayisi == '0) ? BITIR : OKU0;
      OKU0:    state_d = OKU1;
      OKU1:    state_d = OKU2;
      OKU2:    state_d = OKU3;
      OKU3:    state_d = BEKLE;
      BEKLE: begin
        if (alu.alu_bitti)      state_d = YAZ;
        else if (zaman_asimi_c) state_d = BITIR;
      end
      YAZ:     state_d = son_islem_c ? BITIR : OKU0;
      BITIR:   state_d = BOSTA;
      default: state_d = BOSTA;
    endcase
  end

  // Output/datapath next values, looked ahead on state_d so registered outputs track the state
  always_comb begin
    n_d         = n_q;
    i_d         = i_q;
    taban_d     = taban_q;
    hata_d      = hata_q;
    mem_adres_d = mem_adres_q;
    sayi1_d     = sayi1_q;
    sayi2_d     = sayi2_q;
    tur_d       = tur_q;
    alu_adres_d = alu_adres_q;
    yaz_adres_d = yaz_adres_q;
    yaz_veri_d  = yaz_veri_q;
    sayac_d     = '0;

    if (kabul_c) begin
      n_d     = islem_sayisi;
      i_d     = '0;
      taban_d = '0;
      hata_d  = 1'b0;
    end
    if (state_q == YAZ && !son_islem_c) begin
      i_d     = i_q + ADDR_W'(1);
      taban_d = taban_q + ADDR_W'(3);
    end
    if (state_q == BEKLE) begin
      if (alu.alu_bitti)      yaz_veri_d = alu.alu_sonuc;
      else if (zaman_asimi_c) hata_d     = 1'b1;
      if (state_d == BEKLE)   sayac_d    = sayac_q + SAYAC_W'(1);
    end

    if (state_q == OKU1) sayi1_d = mem_veri;
    if (state_q == OKU2) sayi2_d = mem_veri;
    if (state_q == OKU3) tur_d   = mem_veri[1:0];

    case (state_d)
      OKU0:    mem_adres_d = taban_d;
      OKU1:    mem_adres_d = taban_q + ADDR_W'(1);
      OKU2:    mem_adres_d = taban_q + ADDR_W'(2);
      OKU3:    alu_adres_d = i_q;
      YAZ:     yaz_adres_d = i_q;
      default: ;
    endcase

    alu_enable_d = (state_d == BEKLE);
    yaz_en_d     = (state_d == YAZ);
    bitti_d      = (state_d == BITIR);
    mesgul_d     = (state_d != BOSTA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q          <= '0;
      i_q          <= '0;
      taban_q      <= '0;
      sayac_q      <= '0;
      mem_adres_q  <= '0;
      sayi1_q      <= '0;
      sayi2_q      <= '0;
      tur_q        <= '0;
      alu_adres_q  <= '0;
      alu_enable_q <= 1'b0;
      yaz_en_q     <= 1'b0;
      yaz_adres_q  <= '0;
      yaz_veri_q   <= '0;
      mesgul_q     <= 1'b0;
      bitti_q      <= 1'b0;
      hata_q       <= 1'b0;
    end else begin
      n_q          <= n_d;
      i_q          <= i_d;
      taban_q      <= taban_d;
      sayac_q      <= sayac_d;
      mem_adres_q  <= mem_adres_d;
      sayi1_q      <= sayi1_d;
      sayi2_q      <= sayi2_d;
      tur_q        <= tur_d;
      alu_adres_q  <= alu_adres_d;
      alu_enable_q <= alu_enable_d;
      yaz_en_q     <= yaz_en_d;
      yaz_adres_q  <= yaz_adres_d;
      yaz_veri_q   <= yaz_veri_d;
      mesgul_q     <= mesgul_d;
      bitti_q      <= bitti_d;
      hata_q       <= hata_d;
    end
  end

  assign mem_adres          = mem_adres_q;
  assign alu.alu_enable     = alu_enable_q;
  assign alu.alu_sayi1      = sayi1_q;
  assign alu.alu_sayi2      = sayi2_q;
  assign alu.alu_islem_turu = tur_q;
  assign alu.alu_adres      = alu_adres_q;
  assign yaz_en             = yaz_en_q;
  assign yaz_adres          = yaz_adres_q;
  assign yaz_veri           = yaz_veri_q;
  assign mesgul             = mesgul_q;
  assign bitti              = bitti_q;
  assign hata               = hata_q;
endmodule

// File: tb/tb_islem_denetleyici.sv
// Bench for islem_denetleyici: operand RAM, behavioural islem unit and event log checked per scenario.
module tb_islem_denetleyici;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  typedef struct packed { logic [31:0] cyc; logic [AW-1:0] adr; logic [DW-1:0] veri; } yazma_t;
  typedef struct packed { logic [DW-1:0] s1; logic [DW-1:0] s2; logic [1:0] tur; logic [AW-1:0] adr; } op_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          basla = 1'b0;
  logic [AW-1:0] islem_sayisi = '0;
  logic [AW-1:0] mem_adres;
  logic [DW-1:0] mem_veri = '0;
  logic          yaz_en, mesgul, bitti, hata;
  logic [AW-1:0] yaz_adres;
  logic [DW-1:0] yaz_veri;

  islem_denetleyici_if #(.ADDR_W(AW), .DATA_W(DW)) alu_if ();

  islem_denetleyici #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .basla(basla), .islem_sayisi(islem_sayisi),
    .mem_adres(mem_adres), .mem_veri(mem_veri), .alu(alu_if),
    .yaz_en(yaz_en), .yaz_adres(yaz_adres), .yaz_veri(yaz_veri),
    .mesgul(mesgul), .bitti(bitti), .hata(hata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Operand RAM with one-cycle read latency
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) mem_veri <= ram[mem_adres];

  // Behavioural islem unit: answers after bekle_tbl[adres] BEKLE cycles (0 = never)
  int            bekle_tbl [16];
  int            bekle_say = 0;
  logic          resp_bitti = 1'b0;
  logic          zorla_bitti = 1'b0;
  logic [DW-1:0] resp_sonuc = '0;
  logic          sabit_gecerli = 1'b0;
  logic [DW-1:0] sabit_sonuc = '0;

  assign alu_if.alu_bitti = resp_bitti | zorla_bitti;
  assign alu_if.alu_sonuc = resp_sonuc;

  function automatic logic [DW-1:0] islem_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [1:0] t);
    if (sabit_gecerli) return sabit_sonuc;
    case (t)
      2'b00:   return a + b;
      2'b01:   return a * b;
      2'b10:   return a - b;
      default: return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  always @(negedge clk) begin
    if (alu_if.alu_enable) begin
      bekle_say <= bekle_say + 1;
      if (bekle_tbl[alu_if.alu_adres[3:0]] == bekle_say + 1) begin
        resp_bitti <= 1'b1;
        resp_sonuc <= islem_model(alu_if.alu_sayi1, alu_if.alu_sayi2, alu_if.alu_islem_turu);
      end else begin
        resp_bitti <= 1'b0;
      end
    end else begin
      bekle_say  <= 0;
      resp_bitti <= 1'b0;
    end
  end

  // Event log
  int            cyc = 0;
  int            mesgul_bas = 0;
  int            son_bitti = 0;
  int            bitti_say = 0;
  int            en_say = 0;
  int            kararsiz = 0;
  logic          mesgul_onceki = 1'b0;
  logic          en_onceki = 1'b0;
  op_t           onceki_op = '0;
  logic [AW-1:0] adres_log [$];
  yazma_t        yaz_log [$];
  op_t           op_log [$];

  always @(negedge clk) begin
    cyc           <= cyc + 1;
    mesgul_onceki <= mesgul;
    en_onceki     <= alu_if.alu_enable;
    if (mesgul && !mesgul_onceki) mesgul_bas <= cyc;
    if (mesgul) adres_log.push_back(mem_adres);
    if (yaz_en) yaz_log.push_back(yazma_t'({32'(cyc), yaz_adres, yaz_veri}));
    if (bitti) begin
      bitti_say <= bitti_say + 1;
      son_bitti <= cyc;
    end
    if (alu_if.alu_enable) begin
      en_say    <= en_say + 1;
      onceki_op <= op_t'({alu_if.alu_sayi1, alu_if.alu_sayi2, alu_if.alu_islem_turu, alu_if.alu_adres});
      if (!en_onceki)
        op_log.push_back(op_t'({alu_if.alu_sayi1, alu_if.alu_sayi2, alu_if.alu_islem_turu, alu_if.alu_adres}));
      else if (onceki_op !== op_t'({alu_if.alu_sayi1, alu_if.alu_sayi2, alu_if.alu_islem_turu, alu_if.alu_adres}))
        kararsiz <= kararsiz + 1;
    end
  end

  task automatic basla_ver(input int n);
    @(negedge clk);
    islem_sayisi = AW'(n);
    basla = 1'b1;
    @(negedge clk);
    basla = 1'b0;
  endtask

  task automatic bitti_bekle(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      @(negedge clk);
      if (bitti) ok = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_adres, yaz_en, yaz_adres, yaz_veri, bitti, hata, alu_if.alu_enable, alu_if.alu_sayi1,
         alu_if.alu_sayi2, alu_if.alu_islem_turu, alu_if.alu_adres} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: mem_adres=%h yaz_en=%b yaz_veri=%h bitti=%b hata=%b en=%b s1=%h s2=%h tur=%b adr=%h, required all 0",
               mem_adres, yaz_en, yaz_veri, bitti, hata, alu_if.alu_enable, alu_if.alu_sayi1,
               alu_if.alu_sayi2, alu_if.alu_islem_turu, alu_if.alu_adres);
    end
    checks++;
    if (mesgul !== 1'b0) begin errors++; $display("FAIL reset_mesgul: got %b required 0", mesgul); end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    int y0;
    int b0;
    bit ok;
    y0 = yaz_log.size();
    b0 = bitti_say;
    ram[0] = 32'h3F800000; ram[1] = 32'h40000000; ram[2] = 32'h0;
    bekle_tbl[0] = 5;
    sabit_gecerli = 1'b1;
    sabit_sonuc = 32'h40400000;
    basla_ver(1);
    bitti_bekle(60, ok);
    sabit_gecerli = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL add_done: no bitti within 60 cycles"); end
    checks++;
    if (yaz_log.size() != y0 + 1) begin
      errors++; $display("FAIL add_write_count: got %0d required 1", yaz_log.size() - y0);
    end else begin
      checks++;
      if (yaz_log[y0].adr !== '0 || yaz_log[y0].veri !== 32'h40400000) begin
        errors++; $display("FAIL add_write: adres %h veri %h, required 0 / 40400000", yaz_log[y0].adr, yaz_log[y0].veri);
      end
      checks++;
      if (int'(yaz_log[y0].cyc) != mesgul_bas + 9) begin
        errors++; $display("FAIL add_latency: write at +%0d, required +9", int'(yaz_log[y0].cyc) - mesgul_bas);
      end
      checks++;
      if (son_bitti != int'(yaz_log[y0].cyc) + 1) begin
        errors++; $display("FAIL add_bitti_timing: bitti at %0d, required %0d", son_bitti, int'(yaz_log[y0].cyc) + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (bitti !== 1'b0 || mesgul !== 1'b0 || hata !== 1'b0 || bitti_say - b0 != 1) begin
      errors++; $display("FAIL add_end: bitti=%b mesgul=%b hata=%b pulses=%0d, required 0/0/0/1", bitti, mesgul, hata, bitti_say - b0);
    end
  endtask

  task automatic test_mixed(input int n, input bit sabit_tur);
    int y0, o0, a0, k0, b0, m, bas, beklenen_cyc;
    int w [16];
    bit ok, sira_ok;
    logic [1:0] tur;
    logic [AW-1:0] son;
    logic [DW-1:0] bek;
    y0 = yaz_log.size(); o0 = op_log.size(); a0 = adres_log.size(); k0 = kararsiz; b0 = bitti_say;
    for (int i = 0; i < n; i++) begin
      tur = sabit_tur ? ((i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b11) : 2'($urandom_range(0, 3));
      ram[3*i]     = $urandom;
      ram[3*i + 1] = $urandom;
      ram[3*i + 2] = {30'b0, tur};
      w[i] = int'($urandom_range(1, TO));
      bekle_tbl[i] = w[i];
    end
    basla_ver(n);
    bitti_bekle(n * 20 + 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mixed_done: n=%0d no bitti", n); end

    sira_ok = 1'b1; m = 0; son = '0;
    for (int k = a0; k < adres_log.size(); k++) begin
      if (k == a0 || adres_log[k] != son) begin
        if (adres_log[k] !== AW'(m)) sira_ok = 1'b0;
        m++;
        son = adres_log[k];
      end
    end
    checks++;
    if (!sira_ok || m != 3 * n) begin
      errors++; $display("FAIL mixed_mem_adres: n=%0d %0d distinct addresses, in-order=%b, required 0..%0d", n, m, sira_ok, 3*n - 1);
    end

    checks++;
    if (yaz_log.size() != y0 + n || op_log.size() != o0 + n) begin
      errors++; $display("FAIL mixed_counts: writes %0d ops %0d, required %0d", yaz_log.size() - y0, op_log.size() - o0, n);
    end else begin
      bas = mesgul_bas;
      for (int i = 0; i < n; i++) begin
        bek = islem_model(ram[3*i], ram[3*i + 1], ram[3*i + 2][1:0]);
        checks++;
        if (yaz_log[y0 + i].adr !== AW'(i) || yaz_log[y0 + i].veri !== bek) begin
          errors++; $display("FAIL mixed_write[%0d]: adres %h veri %h, required %h / %h", i, yaz_log[y0 + i].adr, yaz_log[y0 + i].veri, AW'(i), bek);
        end
        checks++;
        if (op_log[o0 + i] !== op_t'({ram[3*i], ram[3*i + 1], ram[3*i + 2][1:0], AW'(i)})) begin
          errors++; $display("FAIL mixed_operands[%0d]: tur %b adr %h s1 %h s2 %h, required tur %b", i, op_log[o0 + i].tur,
                             op_log[o0 + i].adr, op_log[o0 + i].s1, op_log[o0 + i].s2, ram[3*i + 2][1:0]);
        end
        beklenen_cyc = bas + 4 + w[i];
        checks++;
        if (int'(yaz_log[y0 + i].cyc) != beklenen_cyc) begin
          errors++; $display("FAIL mixed_latency[%0d]: write at %0d, required %0d", i, int'(yaz_log[y0 + i].cyc), beklenen_cyc);
        end
        bas = beklenen_cyc + 1;
      end
      checks++;
      if (son_bitti != bas) begin errors++; $display("FAIL mixed_bitti_timing: at %0d required %0d", son_bitti, bas); end
    end
    checks++;
    if (kararsiz != k0 || hata !== 1'b0 || bitti_say - b0 != 1) begin
      errors++; $display("FAIL mixed_misc: unstable %0d hata %b pulses %0d, required 0/0/1", kararsiz - k0, hata, bitti_say - b0);
    end
  endtask

  task automatic test_n0();
    logic [AW-1:0] a;
    int y0, b0;
    a = mem_adres; y0 = yaz_log.size(); b0 = bitti_say;
    basla_ver(0);
    checks++;
    if (bitti !== 1'b1 || mem_adres !== a) begin
      errors++; $display("FAIL n0_bitti: bitti %b mem_adres %h, required 1 / %h", bitti, mem_adres, a);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bitti !== 1'b0 || mesgul !== 1'b0 || yaz_log.size() != y0 || bitti_say - b0 != 1) begin
      errors++; $display("FAIL n0_end: bitti %b mesgul %b writes %0d pulses %0d, required 0/0/0/1", bitti, mesgul, yaz_log.size() - y0, bitti_say - b0);
    end
  endtask

  task automatic test_timeout();
    int y0, e0, b0;
    bit ok;
    y0 = yaz_log.size(); e0 = en_say; b0 = bitti_say;
    for (int i = 0; i < 6; i++) ram[i] = $urandom;
    bekle_tbl[0] = 0;
    basla_ver(2);
    bitti_bekle(60, ok);
    checks++;
    if (!ok || hata !== 1'b1) begin errors++; $display("FAIL timeout_flag: done %b hata %b, required 1/1", ok, hata); end
    checks++;
    if (en_say - e0 != int'(TO) || yaz_log.size() != y0 || bitti_say - b0 != 1) begin
      errors++; $display("FAIL timeout_counts: BEKLE cycles %0d writes %0d pulses %0d, required %0d/0/1", en_say - e0, yaz_log.size() - y0, bitti_say - b0, TO);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (hata !== 1'b1 || mesgul !== 1'b0) begin errors++; $display("FAIL timeout_sticky: hata %b mesgul %b, required 1/0", hata, mesgul); end
    basla_ver(0);
    checks++;
    if (hata !== 1'b0) begin errors++; $display("FAIL timeout_clear: hata %b required 0", hata); end
    @(negedge clk);
  endtask

  task automatic test_spurious();
    int y0, e0, b0;
    bit ok, gordu;
    logic [DW-1:0] bek;
    y0 = yaz_log.size(); e0 = en_say; b0 = bitti_say;
    ram[0] = $urandom; ram[1] = $urandom; ram[2] = 32'h1;
    bekle_tbl[0] = int'(TO);
    basla_ver(1);
    @(negedge clk);
    zorla_bitti = 1'b1;
    @(negedge clk);
    zorla_bitti = 1'b0;
    gordu = 1'b0;
    for (int k = 0; k < 20 && !gordu; k++) begin
      @(negedge clk);
      if (alu_if.alu_enable) gordu = 1'b1;
    end
    checks++;
    if (!gordu) begin errors++; $display("FAIL spur_enable: alu_enable not seen within 20 cycles"); end
    islem_sayisi = AW'(5);
    basla = 1'b1;
    @(negedge clk);
    basla = 1'b0;
    bitti_bekle(40, ok);
    bek = islem_model(ram[0], ram[1], 2'b01);
    checks++;
    if (!ok || hata !== 1'b0 || en_say - e0 != int'(TO)) begin
      errors++; $display("FAIL spur_flow: done %b hata %b BEKLE cycles %0d, required 1/0/%0d", ok, hata, en_say - e0, TO);
    end
    checks++;
    if (yaz_log.size() != y0 + 1) begin
      errors++; $display("FAIL spur_write_count: got %0d required 1", yaz_log.size() - y0);
    end else if (yaz_log[y0].adr !== '0 || yaz_log[y0].veri !== bek || int'(yaz_log[y0].cyc) != mesgul_bas + 4 + int'(TO)) begin
      errors++; $display("FAIL spur_write: adres %h veri %h at +%0d, required 0 / %h at +%0d", yaz_log[y0].adr,
                         yaz_log[y0].veri, int'(yaz_log[y0].cyc) - mesgul_bas, bek, 4 + TO);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (mesgul !== 1'b0 || bitti_say - b0 != 1) begin
      errors++; $display("FAIL spur_restart: mesgul %b pulses %0d, required 0/1", mesgul, bitti_say - b0);
    end
  endtask

  task automatic test_reset_mid();
    int y0, b0;
    bit gordu;
    y0 = yaz_log.size(); b0 = bitti_say;
    bekle_tbl[0] = 0;
    basla_ver(2);
    gordu = 1'b0;
    for (int k = 0; k < 20 && !gordu; k++) begin
      @(negedge clk);
      if (alu_if.alu_enable) gordu = 1'b1;
    end
    checks++;
    if (!gordu) begin errors++; $display("FAIL rstmid_enable: alu_enable not seen within 20 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mesgul, bitti, yaz_en, alu_if.alu_enable, hata, mem_adres, alu_if.alu_sayi1, alu_if.alu_adres} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: mesgul %b bitti %b yaz_en %b en %b mem_adres %h s1 %h, required all 0",
                         mesgul, bitti, yaz_en, alu_if.alu_enable, mem_adres, alu_if.alu_sayi1);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (yaz_log.size() != y0 || bitti_say != b0 || mem_adres !== '0 || mesgul !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: writes %0d pulses %0d mem_adres %h mesgul %b, required 0/0/0/0",
                         yaz_log.size() - y0, bitti_say - b0, mem_adres, mesgul);
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) bekle_tbl[i] = 0;
    test_reset();
    test_single_add();
    test_mixed(3, 1'b1);
    repeat (4) test_mixed(int'($urandom_range(1, 6)), 1'b0);
    test_n0();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
